div_share_arbiter: RTL
======================

Name: div_share_arbiter

Overview:
- Shares one FSMD divider core among NUM_REQ requesters.
- Round-robin arbitration; latches the winner's operands, pulses the divider start, waits a fixed latency, then registers the quotient/remainder and returns them tagged with the requester ID.
- Handles divide-by-zero locally without starting the divider.
- Sits between client blocks and the divider instance; drives the divider's operand and start inputs and reads its outputs.

Parameters:
- WORD_SIZE, 32, operand/result width; must match the attached divider.
- NUM_REQ, 4, number of requesters (2..16).
- ID_SIZE, 2, width of resp_id; must be >= ceil(log2(NUM_REQ)).
- DIV_LATENCY, 34, WAIT cycles after div_start before outputs are sampled; must be >= WORD_SIZE+2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_ack.
- req_dividend  in  NUM_REQ*WORD_SIZE  flattened dividends; requester i at bits [i*WORD_SIZE +: WORD_SIZE].
- req_divisor  in  NUM_REQ*WORD_SIZE  flattened divisors; same packing.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; operands captured this cycle.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  ID_SIZE  index of the requester the result belongs to.
- resp_quotient  out  WORD_SIZE  registered quotient.
- resp_remainder  out  WORD_SIZE  registered remainder.
- resp_dbz  out  1  divide-by-zero flag, valid with resp_valid.
- busy  out  1  high in any state other than IDLE.
- div_start  out  1  divider start.
- div_dividend  out  WORD_SIZE  divider dividend, from the latched operand register.
- div_divisor  out  WORD_SIZE  divider divisor, from the latched operand register.
- div_quotient  in  WORD_SIZE  divider quotient.
- div_remainder  in  WORD_SIZE  divider remainder.

Behaviour:
- Reset (rst low, async), all registered state to 0:
  - state=IDLE; rr pointer=0; wait counter=0; operand registers=0.
  - resp_valid=0, resp_id=0, resp_quotient=0, resp_remainder=0, resp_dbz=0.
  - div_start=0, req_ack=0, busy=0.
  - Reset mid-operation abandons the operation with no response. The requester already acked is not re-served unless it raises req_valid again.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  - req_ack[winner] is asserted combinationally in this cycle (cycle T0).
  - At the clock edge: latch the winner's operands and ID; pointer <= (winner+1) mod NUM_REQ.
  - If the latched divisor is nonzero, go to ISSUE. If it is zero, go to RESP with quotient={WORD_SIZE{1}}, remainder=dividend, dbz=1.
  - No req_valid high: stay in IDLE; req_ack=0.
- ISSUE (T0+1): div_start=1 for exactly one cycle; load wait counter with DIV_LATENCY; go to WAIT.
- WAIT:
  - div_start=0; counter decrements each cycle.
  - In the cycle the counter equals 1, register div_quotient/div_remainder into the response registers with dbz=0, then go to RESP.
  - WAIT therefore lasts exactly DIV_LATENCY cycles (T0+2 .. T0+1+DIV_LATENCY).
- RESP: resp_valid=1 for one cycle; resp_* hold the registered values; return to IDLE.
- Response timing: normal response at T0+2+DIV_LATENCY; divide-by-zero response at T0+1.
- Back-to-back: the next grant occurs in the IDLE cycle after RESP.
- resp_quotient, resp_remainder, resp_id and resp_dbz hold their last values until the next response; resp_valid is the only strobe.
- div_dividend and div_divisor stay stable from ISSUE through the end of WAIT.
- req_valid changes during non-IDLE states are ignored. A requester that drops req_valid before its ack is simply not granted.
- Only one operation is in flight at a time; there is no queuing.

Optional Feature:
- DIV_SHARE_STATS_EN defined:
  - Adds output stat_ops (16 bits): completed responses, saturating at 16'hFFFF.
  - Adds output stat_dbz (16 bits): divide-by-zero responses, saturating.
  - Adds input stat_clr (1 bit): synchronous clear of both counters; it wins over a simultaneous increment.
  - Both counters are 0 on reset.
- Not defined: these ports and counters do not exist.

Test Plan:
- Single request: req0 100/7 at T0 -> req_ack=4'b0001 at T0; div_start at T0+1; resp_valid at T0+36 with quotient=14, remainder=2, id=0, dbz=0.
- Fairness: req_valid=4'b1111 held continuously -> grant order 0,1,2,3,0; each grant follows the previous RESP by exactly one cycle.
- Divide by zero: req2 0xDEAD/0 -> resp_valid at T0+1 with quotient=0xFFFFFFFF, remainder=0xDEAD, dbz=1, id=2; div_start never asserted.
- Pointer wrap: pointer=3, req_valid=4'b1001 -> requester 3 granted, then requester 0.
- Reset in WAIT: rst low for 1 cycle at T0+10 -> all outputs 0, busy=0, no resp_valid; a new req1 20/3 afterwards -> quotient=6, remainder=2.
- Boundary operands: 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. 5/9 -> quotient=0, remainder=5.

Source files
------------

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one fixed-latency divider core among NUM_REQ
// requesters using round-robin arbitration.
//
// Optional feature macro: DIV_SHARE_STATS_EN (adds stat_clr/stat_ops/stat_dbz).
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   req_valid             per-requester request, held until its req_ack
//   req_dividend/divisor  flattened operands, requester i at [i*WORD_SIZE +: WORD_SIZE]
//   req_ack               one-hot grant pulse, operands captured this cycle
//   resp_valid            one-cycle result strobe
//   resp_id               requester index of the result
//   resp_quotient/remainder/dbz  registered result, held until the next response
//   busy                  high whenever the FSM is not in IDLE
//   div_start             one-cycle divider start
//   div_dividend/divisor  operands to the divider, stable ISSUE..end of WAIT
//   div_quotient/remainder  divider results
//   stat_clr, stat_ops, stat_dbz  (DIV_SHARE_STATS_EN only) saturating counters
module div_share_arbiter #(
   parameter int unsigned WORD_SIZE   = 32,
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_SIZE     = 2,
   parameter int unsigned DIV_LATENCY = 34
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_dividend,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_divisor,
   output logic [NUM_REQ-1:0]           req_ack,
   output logic                         resp_valid,
   output logic [ID_SIZE-1:0]           resp_id,
   output logic [WORD_SIZE-1:0]         resp_quotient,
   output logic [WORD_SIZE-1:0]         resp_remainder,
   output logic                         resp_dbz,
   output logic                         busy,
   output logic                         div_start,
   output logic [WORD_SIZE-1:0]         div_dividend,
   output logic [WORD_SIZE-1:0]         div_divisor,
   input  logic [WORD_SIZE-1:0]         div_quotient,
   input  logic [WORD_SIZE-1:0]         div_remainder
`ifdef DIV_SHARE_STATS_EN
   ,
   input  logic                         stat_clr,
   output logic [15:0]                  stat_ops,
   output logic [15:0]                  stat_dbz
`endif
);

   localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);
   localparam int unsigned SUM_W = ID_SIZE + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                 state;
   logic [ID_SIZE-1:0]     ptr;
   logic [ID_SIZE-1:0]     cur_id;
   logic [CNT_W-1:0]       wait_cnt;
   logic [WORD_SIZE-1:0]   op_dividend;
   logic [WORD_SIZE-1:0]   op_divisor;

   logic                   win_found;
   logic [ID_SIZE-1:0]     win_id;
   logic [ID_SIZE-1:0]     ptr_next;
   logic [SUM_W-1:0]       sum;
   logic [2*NUM_REQ-1:0]   req_dbl;
   logic [NUM_REQ-1:0]     req_rot;
   logic [WORD_SIZE-1:0]   sel_dividend;
   logic [WORD_SIZE-1:0]   sel_divisor;

   // Round-robin pick: rotate requests so the pointer sits at bit 0, take the
   // lowest set bit, then map the offset back to an absolute index.
   always_comb begin
      req_dbl   = {req_valid, req_valid};
      req_rot   = NUM_REQ'(req_dbl >> ptr);
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            sum       = SUM_W'(ptr) + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            win_id    = ID_SIZE'(sum);
         end
      end
   end

   // Operand mux for the winner.
   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_id == ID_SIZE'(j)) begin
            sel_dividend = req_dividend[j*WORD_SIZE +: WORD_SIZE];
            sel_divisor  = req_divisor[j*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   assign ptr_next = (win_id == ID_SIZE'(NUM_REQ - 1)) ? '0 : win_id + ID_SIZE'(1);

   // Grant is combinational so the requester sees its ack in the capture cycle.
   assign req_ack = (state == IDLE && win_found && rst) ? (NUM_REQ'(1) << win_id) : '0;

   assign div_dividend = op_dividend;
   assign div_divisor  = op_divisor;

   // Control FSM, operand latch and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         ptr            <= '0;
         cur_id         <= '0;
         wait_cnt       <= '0;
         op_dividend    <= '0;
         op_divisor     <= '0;
         resp_valid     <= 1'b0;
         resp_id        <= '0;
         resp_quotient  <= '0;
         resp_remainder <= '0;
         resp_dbz       <= 1'b0;
         busy           <= 1'b0;
         div_start      <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         div_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_dividend <= sel_dividend;
                  op_divisor  <= sel_divisor;
                  cur_id      <= win_id;
                  ptr         <= ptr_next;
                  busy        <= 1'b1;
                  if (sel_divisor == '0) begin
                     // Divide-by-zero answered locally; the divider is never started.
                     resp_quotient  <= '1;
                     resp_remainder <= sel_dividend;
                     resp_dbz       <= 1'b1;
                     resp_id        <= win_id;
                     resp_valid     <= 1'b1;
                     state          <= RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= CNT_W'(DIV_LATENCY);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == CNT_W'(1)) begin
                  resp_quotient  <= div_quotient;
                  resp_remainder <= div_remainder;
                  resp_dbz       <= 1'b0;
                  resp_id        <= cur_id;
                  resp_valid     <= 1'b1;
                  wait_cnt       <= '0;
                  state          <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DIV_SHARE_STATS_EN
   // Saturating response counters; clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_ops <= '0;
         stat_dbz <= '0;
      end else if (stat_clr) begin
         stat_ops <= '0;
         stat_dbz <= '0;
      end else if (resp_valid) begin
         if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
         if (resp_dbz && stat_dbz != 16'hFFFF) stat_dbz <= stat_dbz + 16'd1;
      end
   end
`endif

endmodule
